rx_sample_delay_aligner: RTL

//   Multi-channel, runtime-programmable sample delay line that re-aligns the
//   raw input stream with late-arriving PSS peak detections before frame_sync.

---
 rtl/rx_sample_delay_aligner.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rx_sample_delay_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_sample_delay_aligner                                                  |
// | Programmable multi-channel sample delay that re-aligns PSS peak markers. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rx_sample_delay_aligner #(
  parameter int IN_DW         = 32,
  parameter int N_CH          = 1,
  parameter int MAX_DELAY     = 64,
  parameter int DEFAULT_DELAY = 14,
  parameter int TAG_DW        = 2,
  localparam int DELAY_W      = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [N_CH*IN_DW-1:0] s_axis_in_tdata,
  input  logic                  s_axis_in_tvalid,
  input  logic [DELAY_W-1:0]    delay_i,
  input  logic                  delay_valid_i,
  input  logic                  peak_i,
  input  logic [TAG_DW-1:0]     peak_tag_i,
  output logic [N_CH*IN_DW-1:0] m_axis_out_tdata,
  output logic                  m_axis_out_tvalid,
  output logic                  peak_o,
  output logic [TAG_DW-1:0]     peak_tag_o,
  output logic                  filled_o,
  output logic [DELAY_W-1:0]    delay_o,
  output logic                  peak_overrun_o
);

  localparam int DEPTH = 2 ** DELAY_W;
  localparam int DW    = N_CH * IN_DW;
  localparam logic [DELAY_W-1:0] c_max_delay     = DELAY_W'(MAX_DELAY);
  localparam logic [DELAY_W-1:0] c_default_delay = DELAY_W'(DEFAULT_DELAY);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic [DW-1:0]      r_mem [DEPTH];
  logic [DELAY_W-1:0] r_wr_ptr;
  logic [DELAY_W-1:0] r_fill;
  logic [DELAY_W-1:0] r_delay;
  state_t             r_state;
  logic               r_pending;
  logic [TAG_DW-1:0]  r_pend_tag;
  logic [DW-1:0]      r_out_data;
  logic               r_out_valid;
  logic               r_peak;
  logic [TAG_DW-1:0]  r_peak_tag;
  logic               r_overrun;

  logic [DELAY_W-1:0] w_delay_req;
  logic [DELAY_W-1:0] w_delay_eff;
  logic [DELAY_W-1:0] w_rd_addr;
  logic [DELAY_W-1:0] w_fill_after;
  logic               w_out_beat;
  logic               w_peak_emit;

  // A load in the same cycle as a sample already governs that sample's read.
  assign w_delay_req  = (delay_i > c_max_delay) ? c_max_delay : delay_i;
  assign w_delay_eff  = delay_valid_i ? w_delay_req : r_delay;
  assign w_rd_addr    = r_wr_ptr - w_delay_eff;
  assign w_fill_after = (s_axis_in_tvalid && (r_fill != c_max_delay)) ? r_fill + 1'b1 : r_fill;
  assign w_out_beat   = s_axis_in_tvalid && (r_fill >= w_delay_eff);
  assign w_peak_emit  = w_out_beat && (r_pending || peak_i);

  always_ff @(posedge clk_i) begin
    if (s_axis_in_tvalid) begin
      r_mem[r_wr_ptr] <= s_axis_in_tdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_delay     <= c_default_delay;
      r_state     <= ST_EMPTY;
      r_pending   <= 1'b0;
      r_pend_tag  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_peak      <= 1'b0;
      r_peak_tag  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (delay_valid_i) begin
        r_delay <= w_delay_req;
      end
      if (s_axis_in_tvalid) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_fill <= w_fill_after;

      r_out_valid <= w_out_beat;
      if (w_out_beat) begin
        r_out_data <= (w_delay_eff == '0) ? s_axis_in_tdata : r_mem[w_rd_addr];
      end

      r_peak <= w_peak_emit;
      if (w_peak_emit) begin
        r_peak_tag <= r_pending ? r_pend_tag : peak_tag_i;
      end
      // A new peak stays pending unless it rides out on this beat itself.
      if (peak_i) begin
        r_pend_tag <= peak_tag_i;
        r_pending  <= r_pending || !w_out_beat;
        if (r_pending && !w_out_beat) begin
          r_overrun <= 1'b1;
        end
      end else if (w_out_beat) begin
        r_pending <= 1'b0;
      end

      if (w_fill_after == '0) begin
        r_state <= ST_EMPTY;
      end else if (w_fill_after >= w_delay_eff) begin
        r_state <= ST_RUN;
      end else begin
        r_state <= ST_FILL;
      end
    end
  end

  assign m_axis_out_tdata  = r_out_data;
  assign m_axis_out_tvalid = r_out_valid;
  assign peak_o            = r_peak;
  assign peak_tag_o        = r_peak_tag;
  assign filled_o          = (r_state == ST_RUN);
  assign delay_o           = r_delay;
  assign peak_overrun_o    = r_overrun;

endmodule
`default_nettype wire
